lcd_line_capture: RTL and testbench

- Downstream consumer of the PPU display outputs (lcd_pixel, lcd_color, lcd_hsync, lcd_vsync).
- Maps each raw 2-bit pixel through the BGP palette and packs 4 shades per byte, MSB-first.
- Tracks screen position from the sync edges and emits framebuffer byte writes (address + data) through a small FIFO with a valid/ready handshake.
- The framebuffer/scan-out side drains this FIFO at its own rate.

---
 rtl/lcd_line_capture_if.sv | 16 +
 rtl/lcd_line_capture.sv | 152 +++++++++++++++
 tb/tb_lcd_line_capture.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_line_capture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : lcd_line_capture_if
// Purpose  : Framebuffer byte-write channel (address, data, valid/ready).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface lcd_line_capture_if;
   logic [12:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_valid;
   logic        fb_ready;

   modport master (output fb_addr, output fb_data, output fb_valid, input fb_ready);
   modport slave  (input fb_addr, input fb_data, input fb_valid, output fb_ready);
endinterface
`default_nettype wire

// File: rtl/lcd_line_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : lcd_line_capture
// Purpose  : Palette-maps PPU pixels, packs 4 shades per byte and queues
//            framebuffer writes in a small FIFO.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module lcd_line_capture #(
   parameter int FIFO_DEPTH  = 4,
   parameter int LINE_PIXELS = 160,
   parameter int LINES       = 144
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        lcd_pixel,
   input  wire logic [1:0]  lcd_color,
   input  wire logic        lcd_hsync,
   input  wire logic        lcd_vsync,
   input  wire logic [7:0]  bgp,
   lcd_line_capture_if.master fb,
   output logic             frame_start,
   output logic             overflow,
   output logic             line_error
);
   localparam int c_xw = $clog2(LINE_PIXELS + 1);
   localparam int c_yw = $clog2(LINES + 1);
   localparam int c_pw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_xw-1:0] c_line_pixels = c_xw'(LINE_PIXELS);
   localparam logic [c_yw-1:0] c_lines       = c_yw'(LINES);
   localparam logic [12:0]     c_line_bytes  = 13'(LINE_PIXELS / 4);
   localparam logic [c_pw:0]   c_depth       = (c_pw + 1)'(FIFO_DEPTH);

   logic              r_hsync_q, r_vsync_q;
   logic [c_xw-1:0]   r_x;
   logic [c_yw-1:0]   r_y;
   logic [12:0]       r_line_base;
   logic [7:0]        r_pack;
   logic [1:0]        r_cnt;
   logic [12:0]       r_mem_addr [FIFO_DEPTH];
   logic [7:0]        r_mem_data [FIFO_DEPTH];
   logic [c_pw-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_pw:0]     r_count;
   logic              r_frame_start, r_overflow, r_line_error;

   logic              w_hs_rise, w_vs_rise, w_vs_fall, w_line_end;
   logic              w_in_frame, w_accept, w_overrun;
   logic [1:0]        w_shade;
   logic [c_xw-1:0]   w_x_after, w_x_last;
   logic [2:0]        w_cnt_after;
   logic [7:0]        w_pack_after, w_push_data;
   logic [12:0]       w_push_addr;
   logic              w_full_byte, w_flush, w_push, w_pop, w_full, w_write;

   assign w_hs_rise  = lcd_hsync & ~r_hsync_q;
   assign w_vs_rise  = lcd_vsync & ~r_vsync_q;
   assign w_vs_fall  = ~lcd_vsync & r_vsync_q;
   assign w_line_end = w_hs_rise & ~w_vs_rise;

   assign w_in_frame = (r_y < c_lines);
   assign w_accept   = lcd_pixel & w_in_frame & (r_x < c_line_pixels);
   assign w_overrun  = lcd_pixel & w_in_frame & ~(r_x < c_line_pixels);
   assign w_shade    = bgp[{lcd_color, 1'b0} +: 2];

   // State as it stands after this cycle's pixel, so a line end in the same
   // cycle flushes a byte that already includes it.
   assign w_x_after    = r_x + {{(c_xw - 1){1'b0}}, w_accept};
   assign w_x_last     = w_x_after - {{(c_xw - 1){1'b0}}, 1'b1};
   assign w_cnt_after  = {1'b0, r_cnt} + {2'b00, w_accept};
   assign w_pack_after = w_accept ? {r_pack[5:0], w_shade} : r_pack;

   assign w_full_byte  = w_accept & (r_cnt == 2'd3);
   assign w_flush      = w_line_end & (w_cnt_after != 3'd0) & ~w_full_byte;
   assign w_push       = (w_full_byte | w_flush) & ~w_vs_rise;
   assign w_push_addr  = r_line_base + 13'(w_x_last[c_xw-1:2]);

   always_comb begin
      w_push_data = w_pack_after;
      case (w_cnt_after)
         3'd1:    w_push_data = {w_pack_after[1:0], 6'b0};
         3'd2:    w_push_data = {w_pack_after[3:0], 4'b0};
         3'd3:    w_push_data = {w_pack_after[5:0], 2'b0};
         default: w_push_data = w_pack_after;
      endcase
   end

   assign w_pop   = fb.fb_valid & fb.fb_ready;
   assign w_full  = (r_count == c_depth);
   assign w_write = w_push & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hsync_q     <= 1'b1;
         r_vsync_q     <= 1'b1;
         r_x           <= '0;
         r_y           <= '0;
         r_line_base   <= '0;
         r_pack        <= '0;
         r_cnt         <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_frame_start <= 1'b0;
         r_overflow    <= 1'b0;
         r_line_error  <= 1'b0;
      end else begin
         r_hsync_q     <= lcd_hsync;
         r_vsync_q     <= lcd_vsync;
         r_frame_start <= w_vs_fall;
         if (w_push & w_full & ~w_pop)
            r_overflow <= 1'b1;
         if (w_overrun | (w_line_end & w_in_frame & (w_x_after != c_line_pixels)))
            r_line_error <= 1'b1;
         if (w_accept)
            r_pack <= w_pack_after;

         if (w_vs_rise) begin
            r_x         <= '0;
            r_y         <= '0;
            r_line_base <= '0;
            r_cnt       <= '0;
         end else if (w_line_end) begin
            r_x   <= '0;
            r_cnt <= '0;
            // y saturates at LINES so the address never walks past the frame
            if (w_in_frame) begin
               r_y         <= r_y + 1'b1;
               r_line_base <= r_line_base + c_line_bytes;
            end
         end else if (w_accept) begin
            r_x   <= w_x_after;
            r_cnt <= w_cnt_after[1:0];
         end

         if (w_write) begin
            r_mem_addr[r_wr_ptr] <= w_push_addr;
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_wr_ptr             <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (c_pw + 1)'(w_write) - (c_pw + 1)'(w_pop);
      end
   end

   assign fb.fb_valid = (r_count != '0);
   assign fb.fb_addr  = r_mem_addr[r_rd_ptr];
   assign fb.fb_data  = r_mem_data[r_rd_ptr];
   assign frame_start = r_frame_start;
   assign overflow    = r_overflow;
   assign line_error  = r_line_error;
endmodule
`default_nettype wire

// File: tb/tb_lcd_line_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_lcd_line_capture
// Purpose  : Self-checking bench for lcd_line_capture with a queue-based model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_lcd_line_capture;
   localparam int DEPTH = 4;
   localparam int LP    = 160;
   localparam int NL    = 144;
   localparam int LB    = LP / 4;

   logic       clk = 1'b0;
   logic       rst, lcd_pixel, lcd_hsync, lcd_vsync;
   logic [1:0] lcd_color;
   logic [7:0] bgp;
   logic       frame_start, overflow, line_error;
   int         n_cmp = 0;
   int         n_err = 0;

   lcd_line_capture_if fbi ();

   lcd_line_capture #(.FIFO_DEPTH(DEPTH), .LINE_PIXELS(LP), .LINES(NL)) dut (
      .clk(clk), .rst(rst), .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
      .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .bgp(bgp), .fb(fbi.master),
      .frame_start(frame_start), .overflow(overflow), .line_error(line_error));

   always #5 clk = ~clk;

   // Reference model: screen position, pending shades of the current byte,
   // and the write FIFO as a queue of {addr, data}.
   int          m_x, m_y;
   int          m_pix[$];
   logic [20:0] m_fifo[$];
   bit          m_ovf, m_lerr, m_fs, m_hq, m_vq;

   function automatic logic [20:0] make_entry(int addr);
      logic [7:0] d = 8'h00;
      for (int i = 0; i < m_pix.size(); i++)
         d = d | (8'(m_pix[i]) << (6 - 2 * i));
      return {13'(addr), d};
   endfunction

   task automatic model_step();
      bit          hs_rise, vs_rise, vs_fall, pop, has_push;
      logic [20:0] ent, tmp;
      if (rst) begin
         m_x = 0; m_y = 0; m_pix.delete(); m_fifo.delete();
         m_ovf = 0; m_lerr = 0; m_fs = 0; m_hq = 1; m_vq = 1;
         return;
      end
      hs_rise  = lcd_hsync && !m_hq;
      vs_rise  = lcd_vsync && !m_vq;
      vs_fall  = !lcd_vsync && m_vq;
      pop      = fbi.fb_ready && (m_fifo.size() != 0);
      has_push = 0;
      ent      = '0;
      if (lcd_pixel && m_y < NL) begin
         if (m_x < LP) begin
            m_pix.push_back(int'((bgp >> (2 * lcd_color)) & 8'h03));
            m_x++;
            if (m_pix.size() == 4) begin
               ent = make_entry(m_y * LB + (m_x - 1) / 4);
               has_push = 1;
               m_pix.delete();
            end
         end else m_lerr = 1;
      end
      if (vs_rise) begin
         has_push = 0; m_x = 0; m_y = 0; m_pix.delete();
      end else if (hs_rise) begin
         if (m_y < NL && m_x != LP) m_lerr = 1;
         if (m_pix.size() > 0) begin
            ent = make_entry(m_y * LB + (m_x - 1) / 4);
            has_push = 1;
            m_pix.delete();
         end
         m_x = 0;
         if (m_y < NL) m_y++;
      end
      if (pop) tmp = m_fifo.pop_front();
      if (has_push) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(ent);
         else m_ovf = 1;
      end
      m_fs = vs_fall; m_hq = lcd_hsync; m_vq = lcd_vsync;
   endtask

   task automatic tick(input bit p, input logic [1:0] c, input bit hs, input bit vs, input bit rdy);
      lcd_pixel = p; lcd_color = c; lcd_hsync = hs; lcd_vsync = vs; fbi.fb_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(0, 2'd0, 0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (fbi.fb_valid !== 1'b0 || overflow !== 1'b0 || line_error !== 1'b0 || frame_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset: got valid=%b ovf=%b lerr=%b fs=%b, want all 0",
                  fbi.fb_valid, overflow, line_error, frame_start);
      end
   endtask

   task automatic test_normal_packing();
      do_reset();
      bgp = 8'hE4;
      for (int i = 0; i < 3; i++) tick(1, 2'(i), 0, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b0) begin
         n_err++; $display("FAIL pack_early: valid=%b want 0", fbi.fb_valid);
      end
      tick(1, 2'd3, 0, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b1 || fbi.fb_addr !== 13'd0 || fbi.fb_data !== 8'h1B) begin
         n_err++;
         $display("FAIL pack_write: got v=%b a=%0d d=%h want v=1 a=0 d=1b", fbi.fb_valid, fbi.fb_addr, fbi.fb_data);
      end
      tick(0, 2'd0, 0, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b0) begin
         n_err++; $display("FAIL pack_pop: valid=%b want 0", fbi.fb_valid);
      end
   endtask

   task automatic test_palette_addressing();
      int wr = 0;
      do_reset();
      bgp = 8'h1B;
      for (int i = 0; i < LP; i++) begin
         tick(1, 2'd0, 0, 0, 1);
         if (fbi.fb_valid === 1'b1) begin
            n_cmp++;
            if (fbi.fb_addr !== 13'(wr) || fbi.fb_data !== 8'hFF) begin
               n_err++;
               $display("FAIL pal_line: got a=%0d d=%h want a=%0d d=ff", fbi.fb_addr, fbi.fb_data, wr);
            end
            wr++;
         end
      end
      n_cmp++;
      if (wr != LB) begin
         n_err++; $display("FAIL pal_count: got %0d writes want %0d", wr, LB);
      end
      tick(0, 2'd0, 1, 0, 1);
      tick(0, 2'd0, 0, 0, 1);
      for (int i = 0; i < 4; i++) tick(1, 2'd3, 0, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b1 || fbi.fb_addr !== 13'd40 || fbi.fb_data !== 8'h00 || line_error !== 1'b0) begin
         n_err++;
         $display("FAIL pal_line1: got v=%b a=%0d d=%h lerr=%b want v=1 a=40 d=00 lerr=0",
                  fbi.fb_valid, fbi.fb_addr, fbi.fb_data, line_error);
      end
   endtask

   task automatic test_short_line();
      do_reset();
      bgp = 8'hE4;
      for (int i = 0; i < 4; i++) tick(1, 2'd1, 0, 0, 1);
      n_cmp++;
      if (fbi.fb_addr !== 13'd0 || fbi.fb_data !== 8'h55 || fbi.fb_valid !== 1'b1) begin
         n_err++; $display("FAIL short_b0: got a=%0d d=%h want a=0 d=55", fbi.fb_addr, fbi.fb_data);
      end
      tick(1, 2'd1, 0, 0, 1);
      tick(1, 2'd1, 0, 0, 1);
      tick(0, 2'd0, 1, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b1 || fbi.fb_addr !== 13'd1 || fbi.fb_data !== 8'h50 || line_error !== 1'b1) begin
         n_err++;
         $display("FAIL short_flush: got v=%b a=%0d d=%h lerr=%b want v=1 a=1 d=50 lerr=1",
                  fbi.fb_valid, fbi.fb_addr, fbi.fb_data, line_error);
      end
      tick(0, 2'd0, 0, 0, 1);
      for (int i = 0; i < 4; i++) tick(1, 2'd1, 0, 0, 1);
      n_cmp++;
      if (fbi.fb_addr !== 13'd40 || fbi.fb_data !== 8'h55) begin
         n_err++; $display("FAIL short_next: got a=%0d d=%h want a=40 d=55", fbi.fb_addr, fbi.fb_data);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] head;
      int         got = 0;
      do_reset();
      bgp = 8'($urandom);
      for (int i = 0; i < 20; i++) begin
         tick(1, 2'($urandom), 0, 0, 0);
         if (i == 3) head = m_fifo[0][7:0];
         if (i >= 3) begin
            n_cmp++;
            if (fbi.fb_valid !== 1'b1 || fbi.fb_addr !== 13'd0 || fbi.fb_data !== head) begin
               n_err++;
               $display("FAIL bp_head: got v=%b a=%0d d=%h want v=1 a=0 d=%h", fbi.fb_valid, fbi.fb_addr, fbi.fb_data, head);
            end
         end
         if (i == 15 || i == 19) begin
            n_cmp++;
            if (overflow !== (i == 19)) begin
               n_err++; $display("FAIL bp_overflow@%0d: got %b want %b", i, overflow, i == 19);
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         if (fbi.fb_valid === 1'b1) begin
            n_cmp++;
            if (fbi.fb_addr !== 13'(got)) begin
               n_err++; $display("FAIL bp_drain: got a=%0d want a=%0d", fbi.fb_addr, got);
            end
            got++;
         end
         tick(0, 2'd0, 0, 0, 1);
      end
      n_cmp++;
      if (got != 4 || overflow !== 1'b1) begin
         n_err++; $display("FAIL bp_count: got %0d writes ovf=%b want 4 writes ovf=1", got, overflow);
      end
   endtask

   task automatic test_frame_boundary();
      int fs_cycles = 0;
      do_reset();
      tick(0, 2'd0, 0, 0, 1);
      bgp = 8'($urandom);
      tick(1, 2'($urandom), 0, 0, 1);
      tick(1, 2'($urandom), 0, 0, 1);
      tick(0, 2'd0, 1, 1, 1);
      tick(0, 2'd0, 1, 1, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b0 || frame_start !== 1'b0) begin
         n_err++; $display("FAIL frame_nowrite: got v=%b fs=%b want v=0 fs=0", fbi.fb_valid, frame_start);
      end
      tick(0, 2'd0, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         if (frame_start === 1'b1) fs_cycles++;
         tick(0, 2'd0, 0, 0, 1);
      end
      n_cmp++;
      if (fs_cycles != 1) begin
         n_err++; $display("FAIL frame_start_len: got %0d cycles want 1", fs_cycles);
      end
      for (int i = 0; i < 4; i++) tick(1, 2'($urandom), 0, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b1 || fbi.fb_addr !== 13'd0 || fbi.fb_data !== m_fifo[0][7:0]) begin
         n_err++;
         $display("FAIL frame_next: got v=%b a=%0d d=%h want v=1 a=0 d=%h", fbi.fb_valid, fbi.fb_addr, fbi.fb_data, m_fifo[0][7:0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bgp = 8'($urandom);
      for (int i = 0; i < 14; i++) tick(1, 2'($urandom), 0, 0, 0);
      rst = 1'b1;
      tick(0, 2'd0, 0, 0, 0);
      rst = 1'b0;
      n_cmp++;
      if (fbi.fb_valid !== 1'b0 || overflow !== 1'b0 || line_error !== 1'b0 || frame_start !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid: got v=%b ovf=%b lerr=%b fs=%b want all 0", fbi.fb_valid, overflow, line_error, frame_start);
      end
      for (int i = 0; i < 4; i++) tick(1, 2'($urandom), 0, 0, 1);
      n_cmp++;
      if (fbi.fb_valid !== 1'b1 || fbi.fb_addr !== 13'd0 || fbi.fb_data !== m_fifo[0][7:0]) begin
         n_err++;
         $display("FAIL rst_restart: got v=%b a=%0d d=%h want v=1 a=0 d=%h", fbi.fb_valid, fbi.fb_addr, fbi.fb_data, m_fifo[0][7:0]);
      end
   endtask

   task automatic test_random();
      int phase = 0, rem = LP, hb = 0, vb = 0;
      bit p, hs, vs;
      do_reset();
      bgp = 8'($urandom);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         p = 0; hs = 0; vs = 0;
         if (phase == 0) begin
            p = ($urandom_range(0, 3) != 0);
            if (p) rem--;
            if (rem <= 0) phase = 1;
         end else if (phase == 1) begin
            hs = 1; hb++;
            if (hb == 6) begin
               hb = 0;
               phase = ($urandom_range(0, 5) == 0) ? 2 : 0;
               rem = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LP + 8)) : LP;
               bgp = 8'($urandom);
            end
         end else begin
            hs = 1; vs = 1; vb++;
            if (vb == 5) begin vb = 0; phase = 0; end
         end
         tick(p, 2'($urandom), hs, vs, bit'($urandom_range(0, 1)));
         n_cmp++;
         if (fbi.fb_valid !== (m_fifo.size() != 0) ||
             (m_fifo.size() != 0 && {fbi.fb_addr, fbi.fb_data} !== m_fifo[0]) ||
             overflow !== m_ovf || line_error !== m_lerr || frame_start !== m_fs) begin
            n_err++;
            $display("FAIL random@%0d: got v=%b a=%0d d=%h ovf=%b lerr=%b fs=%b want n=%0d e=%h ovf=%b lerr=%b fs=%b",
                     cyc, fbi.fb_valid, fbi.fb_addr, fbi.fb_data, overflow, line_error, frame_start,
                     m_fifo.size(), (m_fifo.size() != 0) ? m_fifo[0] : 21'h0, m_ovf, m_lerr, m_fs);
         end
      end
   endtask

   initial begin
      rst = 1'b0; lcd_pixel = 1'b0; lcd_color = 2'd0; lcd_hsync = 1'b0; lcd_vsync = 1'b0;
      bgp = 8'hE4; fbi.fb_ready = 1'b0;
      test_reset();
      test_normal_packing();
      test_palette_addressing();
      test_short_line();
      test_backpressure();
      test_frame_boundary();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
